// File: rtl/accel_spi_reader_if.sv
// -----------------------------------------------------------------------------
// accel_spi_reader_if
//
// Purpose: bundles the sample trigger, the ADXL362 SPI pins and the sample
// output bus of accel_spi_reader into one interface.
//
// Signals:
//   clk_20Hz    trigger from the slow clock generator (asynchronous level)
//   ACL_MISO    SPI data from the accelerometer
//   ACL_MOSI    SPI data to the accelerometer
//   ACL_SCLK    SPI clock, mode 0 (idles low)
//   ACL_CSN     SPI chip select, active low
//   acc_x/y/z   latest axis samples, two's complement
//   data_valid  one-cycle pulse when acc_* update
//   busy        high while a frame or its guard interval is in progress
//
// Modports:
//   master  the reader block (drives SPI pins and the sample bus)
//   slave   the environment (sensor plus trigger source plus consumer)
// -----------------------------------------------------------------------------
interface accel_spi_reader_if;
  logic       clk_20Hz;
  logic       ACL_MISO;
  logic       ACL_MOSI;
  logic       ACL_SCLK;
  logic       ACL_CSN;
  logic [7:0] acc_x;
  logic [7:0] acc_y;
  logic [7:0] acc_z;
  logic       data_valid;
  logic       busy;

  modport master (
    input  clk_20Hz,
    input  ACL_MISO,
    output ACL_MOSI,
    output ACL_SCLK,
    output ACL_CSN,
    output acc_x,
    output acc_y,
    output acc_z,
    output data_valid,
    output busy
  );

  modport slave (
    output clk_20Hz,
    output ACL_MISO,
    input  ACL_MOSI,
    input  ACL_SCLK,
    input  ACL_CSN,
    input  acc_x,
    input  acc_y,
    input  acc_z,
    input  data_valid,
    input  busy
  );
endinterface

// File: rtl/accel_spi_reader.sv
// -----------------------------------------------------------------------------
// accel_spi_reader
//
// Purpose: periodic ADXL362 reader. Every rising edge of the 20 Hz slow clock
// (treated as data and synchronised into CLK100MHZ) starts one SPI mode-0
// burst read: command 0x0B, address 0x08, then three data bytes that land in
// X, Y, Z. The three bytes are published together with a one-cycle
// data_valid strobe when the frame completes.
//
// Parameters:
//   SCLK_HALF_DIV  SCLK half-period in CLK100MHZ cycles (2..255), default 50
//
// Ports:
//   CLK100MHZ  system clock
//   reset      asynchronous, active-high reset
//   bus        accel_spi_reader_if.master (trigger, SPI pins, sample outputs)
//
// Build option:
//   ACCEL_INIT_EN  when defined, the block writes POWER_CTL = 0x02
//                  (0x0A, 0x2D, 0x02) right after reset before going idle.
//                  When undefined, the block leaves reset directly in IDLE.
// -----------------------------------------------------------------------------
module accel_spi_reader #(
  parameter int SCLK_HALF_DIV = 50
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  accel_spi_reader_if.master  bus
);

  // Terminal value of the half-period divider.
  localparam logic [7:0] LP_TICK = 8'(SCLK_HALF_DIV - 1);

  // Read frame: read command, XDATA address, three dummy bytes (MOSI low).
  localparam logic [39:0] LP_READ_FRAME = {8'h0B, 8'h08, 24'h000000};
  localparam logic [5:0]  LP_READ_LAST  = 6'd39;

`ifdef ACCEL_INIT_EN
  // Init frame: write command, POWER_CTL address, measurement mode.
  // Left-aligned so the same MSB-first shifter serves both frames.
  localparam logic [39:0] LP_INIT_FRAME = {8'h0A, 8'h2D, 8'h02, 16'h0000};
  localparam logic [5:0]  LP_INIT_LAST  = 6'd23;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_GUARD = 2'd2
`ifdef ACCEL_INIT_EN
    ,
    ST_INIT  = 2'd3
`endif
  } state_t;

`ifdef ACCEL_INIT_EN
  localparam state_t LP_RESET_STATE = ST_INIT;
`else
  localparam state_t LP_RESET_STATE = ST_IDLE;
`endif

  // Trigger synchroniser and edge detector.
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic        r_edge;

  // FSM and SPI datapath.
  state_t      r_state;
  state_t      w_state_nx;
  logic [7:0]  r_div;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_csn;
  logic        r_busy;
  logic        r_valid;
  logic        r_tail;
  logic        r_init_frame;
  logic [5:0]  r_bit;
  logic [5:0]  r_last_bit;
  logic [39:0] r_tx;
  logic [23:0] r_rx;
  logic [7:0]  r_acc_x;
  logic [7:0]  r_acc_y;
  logic [7:0]  r_acc_z;

  // Control strobes decoded by the FSM.
  logic        w_tick;
  logic        w_start;
  logic        w_start_init;
  logic        w_rise;
  logic        w_fall;
  logic        w_done;
  logic        w_guard_end;
  logic        w_last;
  logic [39:0] w_frame;
  logic [5:0]  w_frame_last;

  assign w_tick = (r_div == LP_TICK);
  assign w_last = (r_bit == r_last_bit);

`ifdef ACCEL_INIT_EN
  assign w_frame      = w_start_init ? LP_INIT_FRAME : LP_READ_FRAME;
  assign w_frame_last = w_start_init ? LP_INIT_LAST  : LP_READ_LAST;
`else
  assign w_frame      = LP_READ_FRAME;
  assign w_frame_last = LP_READ_LAST;
`endif

  // Two-flop synchroniser on clk_20Hz plus registered rising-edge detect.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= bus.clk_20Hz;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state <= LP_RESET_STATE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next-state and control strobe decode.
  always_comb begin
    w_state_nx   = r_state;
    w_start      = 1'b0;
    w_start_init = 1'b0;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_done       = 1'b0;
    w_guard_end  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Edges are only honoured here; anywhere else they are dropped.
        if (r_edge) begin
          w_start    = 1'b1;
          w_state_nx = ST_XFER;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (w_tick) begin
          if (r_tail) begin
            // One extra half period after the last SCLK fall keeps CSN low
            // for the hold time before it rises.
            w_done     = 1'b1;
            w_state_nx = ST_GUARD;
          end else if (r_sclk) begin
            w_fall     = 1'b1;
            w_state_nx = ST_XFER;
          end else begin
            w_rise     = 1'b1;
            w_state_nx = ST_XFER;
          end
        end else begin
          w_state_nx = ST_XFER;
        end
      end
      ST_GUARD: begin
        // CSN stays high for one half period before another frame may start.
        if (w_tick) begin
          w_guard_end = 1'b1;
          w_state_nx  = ST_IDLE;
        end else begin
          w_state_nx  = ST_GUARD;
        end
      end
`ifdef ACCEL_INIT_EN
      ST_INIT: begin
        w_start      = 1'b1;
        w_start_init = 1'b1;
        w_state_nx   = ST_XFER;
      end
`endif
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Half-period divider: runs only while a frame or guard is in progress.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_div <= 8'd0;
    end else if ((r_state == ST_XFER) || (r_state == ST_GUARD)) begin
      r_div <= w_tick ? 8'd0 : (r_div + 8'd1);
    end else begin
      r_div <= 8'd0;
    end
  end

  // SPI shifter, pin registers and frame bookkeeping.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_csn        <= 1'b1;
      r_busy       <= 1'b0;
      r_tail       <= 1'b0;
      r_init_frame <= 1'b0;
      r_bit        <= 6'd0;
      r_last_bit   <= LP_READ_LAST;
      r_tx         <= 40'd0;
      r_rx         <= 24'd0;
    end else begin
      if (w_start) begin
        // MOSI bit 0 is valid in the same cycle CSN falls.
        r_csn        <= 1'b0;
        r_busy       <= 1'b1;
        r_sclk       <= 1'b0;
        r_tail       <= 1'b0;
        r_bit        <= 6'd0;
        r_last_bit   <= w_frame_last;
        r_init_frame <= w_start_init;
        r_mosi       <= w_frame[39];
        r_tx         <= {w_frame[38:0], 1'b0};
      end
      if (w_rise) begin
        // MISO is captured on the same clock edge that raises SCLK.
        r_sclk <= 1'b1;
        r_rx   <= {r_rx[22:0], bus.ACL_MISO};
      end
      if (w_fall) begin
        r_sclk <= 1'b0;
        if (w_last) begin
          r_tail <= 1'b1;
          r_mosi <= 1'b0;
        end else begin
          r_bit  <= r_bit + 6'd1;
          r_mosi <= r_tx[39];
          r_tx   <= {r_tx[38:0], 1'b0};
        end
      end
      if (w_done) begin
        r_csn <= 1'b1;
      end
      if (w_guard_end) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Sample outputs: all three axes load together only when a read frame
  // completes, so a partial frame never becomes visible.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_acc_x <= 8'h00;
      r_acc_y <= 8'h00;
      r_acc_z <= 8'h00;
      r_valid <= 1'b0;
    end else if (w_done && !r_init_frame) begin
      r_acc_x <= r_rx[23:16];
      r_acc_y <= r_rx[15:8];
      r_acc_z <= r_rx[7:0];
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.ACL_SCLK   = r_sclk;
  assign bus.ACL_MOSI   = r_mosi;
  assign bus.ACL_CSN    = r_csn;
  assign bus.acc_x      = r_acc_x;
  assign bus.acc_y      = r_acc_y;
  assign bus.acc_z      = r_acc_z;
  assign bus.data_valid = r_valid;
  assign bus.busy       = r_busy;

endmodule

// File: doc/accel_spi_reader.md
# accel_spi_reader

Periodic ADXL362 accelerometer reader for the Nexys A7. It consumes the 20 Hz slow clock from the slow clock generator as a sample trigger and, on each rising edge, performs one SPI burst read of XDATA/YDATA/ZDATA (8-bit). It presents the three axis bytes with a one-cycle valid strobe to downstream logic. All logic runs on CLK100MHZ; `clk_20Hz` is treated as data, never as a clock.

## Interface
- `SCLK_HALF_DIV`, default 50: SCLK half-period in CLK100MHZ cycles (H); 50 gives 1 MHz. Legal range is 2..255.
- `CLK100MHZ  in  1`: system clock, 100 MHz.
- `reset  in  1`: asynchronous, active-high reset.
- `clk_20Hz  in  1`: sample trigger from the slow clock generator; asynchronous to this block.
- `ACL_MISO  in  1`: SPI data from the accelerometer.
- `ACL_MOSI  out  1`: SPI data to the accelerometer.
- `ACL_SCLK  out  1`: SPI clock, mode 0 (idles low).
- `ACL_CSN  out  1`: SPI chip select, active low.
- `acc_x, acc_y, acc_z  out  8`: latest axis samples, two's complement.
- `data_valid  out  1`: one-cycle pulse when `acc_*` update.
- `busy  out  1`: high while a transaction or its guard interval is in progress.

## Operation
- **Trigger path:** 2-flop synchronizer on `clk_20Hz`, then rising-edge detect. A detected edge is accepted only in IDLE. Edges during INIT or a read are dropped, not queued.
- **FSM states:** INIT (present only with the macro), IDLE, XFER, GUARD.
  - IDLE → XFER on an accepted trigger.
  - XFER → GUARD after the last bit.
  - GUARD → IDLE after H cycles.
  - INIT uses the XFER/GUARD machinery and then returns to IDLE.
- **SPI protocol:**
  - Mode 0, MSB first.
  - MOSI changes only while SCLK is low.
  - MISO is sampled on the CLK100MHZ edge where SCLK goes 0→1.
- **Read frame (40 bits):**
  - Bytes 0x0B (read command), 0x08 (XDATA address), then three read bytes.
  - MOSI = 0 during the read bytes.
  - Read bytes land in X, Y, Z order.
- **Update rule:**
  - `acc_*` load all three at once from an internal shift register, only at frame completion.
  - Partial frames never reach the outputs.
- **Bit counter:** 6 bits, counts 0..39 (0..23 for the init frame). A frame-length register selects the terminal count.
- **Reset mid-transaction:**
  - CSN goes high and SCLK/MOSI go low immediately (asynchronous).
  - The FSM returns to its post-reset state.
  - `acc_*` clear to 0.
  - No `data_valid` pulse is produced.

## Timing
- **Reset values:** ACL_CSN = 1, ACL_SCLK = 0, ACL_MOSI = 0, acc_x/y/z = 0x00, data_valid = 0, busy = 0.
- **Trigger latency:** the first CLK100MHZ edge sampling `clk_20Hz` high is cycle 0. The edge is detected at cycle 2, and CSN falls at cycle 3 (T0). `busy` rises in the same cycle as CSN.
- **Bit timing:** for bit k (0-based), SCLK rises at T0+(2k+1)H and falls at T0+(2k+2)H.
  - MOSI bit 0 is valid from T0.
  - Bit k+1 is driven on the falling-edge cycle of bit k.
- **Read frame completion:**
  - Last SCLK fall at T0+80H.
  - At T0+81H: CSN rises, `acc_*` update, and `data_valid` is high for exactly that one cycle.
  - At T0+82H: `busy` falls and the FSM is in IDLE.
  - At H = 50, total busy time is 4100 cycles (41 µs).
- **Back-to-back triggers:** a trigger edge detected in the cycle `busy` falls is accepted. CSN minimum high time is H cycles.
- **Init frame:** SCLK fall at T0+48H, CSN rise at T0+49H, IDLE at T0+50H.

## Configuration
- **`ACCEL_INIT_EN` defined:**
  - On the first clock after reset release, the block enters INIT with `busy` = 1.
  - It writes 0x0A, 0x2D, 0x02 (POWER_CTL = measurement mode), a 24-bit frame with identical SCLK timing.
  - No `data_valid` is produced.
  - It then proceeds to IDLE; triggers during INIT are dropped.
- **Not defined:** the INIT state and its frame logic are absent. The block leaves reset directly in IDLE, and external logic must configure the sensor.

## Test plan
- **Reset values:** assert `reset` mid-read (bit 20) → within the same cycle CSN = 1, SCLK = 0, MOSI = 0, `acc_*` = 0x00, `busy` = 0. No `data_valid` is seen afterwards until a new trigger.
- **Basic read (H = 4, macro off):** raise `clk_20Hz`; the MISO model returns 0x12, 0x34, 0x56 → MOSI shows 0x0B then 0x08; CSN low for 81×4 = 324 cycles; `data_valid` is a single pulse with `acc_x` = 0x12, `acc_y` = 0x34, `acc_z` = 0x56.
- **Trigger during busy:** pulse `clk_20Hz` high/low at T0+100 → exactly one frame and one `data_valid`. A second edge at the cycle `busy` falls → a second frame starts 3 cycles later.
- **Signed / extreme values:** MISO returns 0x80, 0xFF, 0x7F → `acc_x` = 0x80 (−128), `acc_y` = 0xFF (−1), `acc_z` = 0x7F (+127).
- **`ACCEL_INIT_EN` defined:** release reset → 24-bit frame 0x0A, 0x2D, 0x02 with no `data_valid`. A trigger during INIT is ignored, and the first read frame follows only after `busy` falls at T0+50H.
- **SPI mode check:** across all frames, MOSI never changes while SCLK = 1, and SCLK = 0 whenever CSN = 1.
